// File: rtl/leaf_stream_adapter.sv
// Leaf-interface <-> operator stream adapter: one FIFO per channel plus an IDLE/RUN/DRAIN start/done FSM.
// Optional per-channel transfer counters are compiled in with LEAF_ADAPTER_XFER_COUNT_EN.

// Handshake: a word moves when vld and ack are both high at a rising clk edge; ack is the
// registered not-full flag, vld the registered not-empty flag, so no input reaches them combinationally.
module leaf_stream_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_push_data,
   input  logic         i_push_vld,
   output logic         o_push_ack,
   output logic [W-1:0] o_pop_data,
   output logic         o_pop_vld,
   input  logic         i_pop_ack
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_rdy;
   logic          w_push;
   logic          w_pop;

   // r_rdy keeps ack low through reset and raises it on the first cycle after release.
   assign o_push_ack = r_rdy && (r_count != CNT_FULL);
   assign o_pop_vld  = (r_count != '0);
   assign o_pop_data = r_mem[r_rd_ptr];
   assign w_push     = i_push_vld && o_push_ack;
   assign w_pop      = o_pop_vld && i_pop_ack;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rdy    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rdy <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module leaf_stream_adapter #(
   parameter int PAYLOAD_BITS  = 32,
   parameter int NUM_IN_PORTS  = 1,
   parameter int NUM_OUT_PORTS = 1,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
   input  logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
   output logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
   output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
   output logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
   output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    op_in_data,
   output logic [NUM_IN_PORTS-1:0]                 op_in_vld,
   input  logic [NUM_IN_PORTS-1:0]                 op_in_ack,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   op_out_data,
   input  logic [NUM_OUT_PORTS-1:0]                op_out_vld,
   output logic [NUM_OUT_PORTS-1:0]                op_out_ack,
   input  logic                                    ap_start_in,
   output logic                                    ap_start,
   input  logic                                    ap_done,
   output logic                                    busy,
   output logic [32*(NUM_IN_PORTS+NUM_OUT_PORTS)-1:0] xfer_count,
   output logic [1:0]                              o_dbg_state
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   r_ap_start;
   logic   r_busy;
   logic   w_out_empty;

   for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
      leaf_stream_fifo #(.W(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk         (clk),
         .reset       (reset),
         .i_push_data (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .i_push_vld  (vld_interface2user[i]),
         .o_push_ack  (ack_user2interface[i]),
         .o_pop_data  (op_in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .o_pop_vld   (op_in_vld[i]),
         .i_pop_ack   (op_in_ack[i])
      );
   end

   for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
      leaf_stream_fifo #(.W(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk         (clk),
         .reset       (reset),
         .i_push_data (op_out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .i_push_vld  (op_out_vld[j]),
         .o_push_ack  (op_out_ack[j]),
         .o_pop_data  (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .o_pop_vld   (vld_user2interface[j]),
         .i_pop_ack   (ack_interface2user[j])
      );
   end

   assign w_out_empty = ~|vld_user2interface;

   // ap_start/busy are registered from the next state so they track the state with no extra lag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_ap_start <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_ap_start <= (w_state_next == RUN);
         r_busy     <= (w_state_next != IDLE);
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (ap_start_in) w_state_next = RUN;
         RUN:     if (ap_done) w_state_next = DRAIN;
         DRAIN:   if (w_out_empty) w_state_next = ap_start_in ? RUN : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   assign ap_start    = r_ap_start;
   assign busy        = r_busy;
   assign o_dbg_state = r_state;

`ifdef LEAF_ADAPTER_XFER_COUNT_EN
   localparam int NCH = NUM_IN_PORTS + NUM_OUT_PORTS;
   logic [NCH-1:0] w_op_xfer;
   logic [31:0]    r_xfer_cnt [NCH];

   // Counts are taken on the operator side of every channel, input lanes first.
   assign w_op_xfer = {op_out_vld & op_out_ack, op_in_vld & op_in_ack};

   always_ff @(posedge clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (!reset)            r_xfer_cnt[k] <= '0;
         else if (w_op_xfer[k]) r_xfer_cnt[k] <= r_xfer_cnt[k] + 32'd1;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_cnt
      assign xfer_count[k*32 +: 32] = r_xfer_cnt[k];
   end
`else
   assign xfer_count = '0;
`endif
endmodule

// File: tb/tb_leaf_stream_adapter.sv
// Directed bench for leaf_stream_adapter: 2 input lanes, 2 output lanes, FIFO_DEPTH 4.
module tb_leaf_stream_adapter;
   localparam int W  = 32;
   localparam int NI = 2;
   localparam int NO = 2;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NI*W-1:0]   dout_leaf_interface2user;
   logic [NI-1:0]     vld_interface2user;
   logic [NI-1:0]     ack_user2interface;
   logic [NO*W-1:0]   din_leaf_user2interface;
   logic [NO-1:0]     vld_user2interface;
   logic [NO-1:0]     ack_interface2user;
   logic [NI*W-1:0]   op_in_data;
   logic [NI-1:0]     op_in_vld;
   logic [NI-1:0]     op_in_ack;
   logic [NO*W-1:0]   op_out_data;
   logic [NO-1:0]     op_out_vld;
   logic [NO-1:0]     op_out_ack;
   logic              ap_start_in;
   logic              ap_start;
   logic              ap_done;
   logic              busy;
   logic [32*(NI+NO)-1:0] xfer_count;
   logic [1:0]        dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];

   leaf_stream_adapter #(
      .PAYLOAD_BITS(W), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .FIFO_DEPTH(4)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .dout_leaf_interface2user (dout_leaf_interface2user),
      .vld_interface2user       (vld_interface2user),
      .ack_user2interface       (ack_user2interface),
      .din_leaf_user2interface  (din_leaf_user2interface),
      .vld_user2interface       (vld_user2interface),
      .ack_interface2user       (ack_interface2user),
      .op_in_data               (op_in_data),
      .op_in_vld                (op_in_vld),
      .op_in_ack                (op_in_ack),
      .op_out_data              (op_out_data),
      .op_out_vld               (op_out_vld),
      .op_out_ack               (op_out_ack),
      .ap_start_in              (ap_start_in),
      .ap_start                 (ap_start),
      .ap_done                  (ap_done),
      .busy                     (busy),
      .xfer_count               (xfer_count),
      .o_dbg_state              (dbg_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Driver tasks: inputs change and outputs are sampled at the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int got, got0, got1, idx0, idx1, start_cycles, stale;
      logic xfer_in, p0, p1;
      logic [31:0] exp_cnt;

      reset = 1'b0;
      dout_leaf_interface2user = '0;
      vld_interface2user = '0;
      ack_interface2user = '0;
      op_in_ack = '0;
      op_out_data = '0;
      op_out_vld = '0;
      ap_start_in = 1'b0;
      ap_done = 1'b0;

      // Reset state
      @(negedge clk);
      tick();
      tick();
      check("rst_ack_in", ack_user2interface, 0);
      check("rst_ack_out", op_out_ack, 0);
      check("rst_vld_out", vld_user2interface, 0);
      check("rst_vld_in", op_in_vld, 0);
      check("rst_ap_start", ap_start, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, ST_IDLE);
      reset = 1'b1;
      tick();
      check("rel_ack_in", ack_user2interface, 2'b11);
      check("rel_ack_out", op_out_ack, 2'b11);

      // Single word through input lane 0
      op_in_ack = 2'b01;
      dout_leaf_interface2user[31:0] = 32'hDEADBEEF;
      vld_interface2user[0] = 1'b1;
      check("t1_pre_vld", op_in_vld[0], 0);
      tick();
      vld_interface2user[0] = 1'b0;
      check("t1_vld", op_in_vld[0], 1);
      check("t1_data", op_in_data[31:0], 32'hDEADBEEF);
      tick();
      check("t1_popped", op_in_vld[0], 0);

      // Fill to full with operator stalled, fifth word held
      op_in_ack = 2'b00;
      for (int k = 0; k < 4; k++) begin
         dout_leaf_interface2user[31:0] = 32'h1000 + 32'(k);
         vld_interface2user[0] = 1'b1;
         exp_q.push_back(32'h1000 + 32'(k));
         check("t2_ack_open", ack_user2interface[0], 1);
         tick();
      end
      check("t2_ack_full", ack_user2interface[0], 0);
      dout_leaf_interface2user[31:0] = 32'h1004;
      exp_q.push_back(32'h1004);
      tick();
      tick();
      check("t2_fifth_held", ack_user2interface[0], 0);
      check("t2_head", op_in_data[31:0], 32'h1000);
      op_in_ack = 2'b01;
      got = 0;
      for (int c = 0; c < 20 && got < 5; c++) begin
         xfer_in = vld_interface2user[0] & ack_user2interface[0];
         if (op_in_vld[0]) begin
            check("t2_order", op_in_data[31:0], exp_q.pop_front());
            got++;
         end
         tick();
         if (xfer_in) vld_interface2user[0] = 1'b0;
      end
      check("t2_count", got, 5);
      check("t2_vld_low", vld_interface2user[0], 0);

      // Two output lanes, random interface-side ack
      for (int k = 0; k < 8; k++) exp_q0.push_back(32'h1 + 32'(k));
      for (int k = 0; k < 6; k++) exp_q1.push_back(32'hA + 32'(k));
      idx0 = 0; idx1 = 0; got0 = 0; got1 = 0;
      for (int c = 0; c < 300 && (got0 < 8 || got1 < 6); c++) begin
         op_out_vld[0] = (idx0 < 8);
         op_out_data[31:0] = 32'h1 + 32'(idx0);
         op_out_vld[1] = (idx1 < 6);
         op_out_data[63:32] = 32'hA + 32'(idx1);
         ack_interface2user = 2'($urandom_range(0, 3));
         #1;
         p0 = op_out_vld[0] & op_out_ack[0];
         p1 = op_out_vld[1] & op_out_ack[1];
         if (vld_user2interface[0] & ack_interface2user[0]) begin
            check("t3_lane0", din_leaf_user2interface[31:0], exp_q0.pop_front());
            got0++;
         end
         if (vld_user2interface[1] & ack_interface2user[1]) begin
            check("t3_lane1", din_leaf_user2interface[63:32], exp_q1.pop_front());
            got1++;
         end
         tick();
         if (p0) idx0++;
         if (p1) idx1++;
      end
      op_out_vld = '0;
      ack_interface2user = '0;
      check("t3_got0", got0, 8);
      check("t3_got1", got1, 6);

      // FSM: done ignored in IDLE, start pulse, done after 10 cycles, drain 3 words
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      check("t4_done_ignored", dbg_state, ST_IDLE);
      check("t4_idle_busy", busy, 0);
      ap_start_in = 1'b1;
      tick();
      ap_start_in = 1'b0;
      check("t4_run_state", dbg_state, ST_RUN);
      check("t4_busy_run", busy, 1);
      start_cycles = int'(ap_start);
      for (int c = 1; c < 10; c++) begin
         op_out_vld[0] = (c <= 3);
         op_out_data[31:0] = 32'h30 + 32'(c);
         if (c <= 3) exp_q0.push_back(32'h30 + 32'(c));
         tick();
         start_cycles += int'(ap_start);
      end
      op_out_vld = '0;
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      check("t4_drain_state", dbg_state, ST_DRAIN);
      for (int c = 0; c < 3; c++) begin
         start_cycles += int'(ap_start);
         tick();
      end
      check("t4_start_cycles", start_cycles, 10);
      check("t4_busy_drain", busy, 1);
      ack_interface2user[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("t4_out_vld", vld_user2interface[0], 1);
         check("t4_out_data", din_leaf_user2interface[31:0], exp_q0.pop_front());
         check("t4_busy_hold", busy, 1);
         tick();
      end
      check("t4_out_empty", vld_user2interface[0], 0);
      check("t4_busy_last", busy, 1);
      tick();
      check("t4_busy_low", busy, 0);
      check("t4_back_idle", dbg_state, ST_IDLE);
      ack_interface2user = '0;

      // Reset mid-operation with 3 words queued
      op_in_ack = 2'b00;
      for (int k = 0; k < 3; k++) begin
         dout_leaf_interface2user[31:0] = 32'h51 + 32'(k);
         vld_interface2user[0] = 1'b1;
         tick();
      end
      vld_interface2user[0] = 1'b0;
      check("t5_queued", op_in_vld[0], 1);
      reset = 1'b0;
      tick();
      check("t5_vld_in_rst", op_in_vld, 0);
      check("t5_vld_out_rst", vld_user2interface, 0);
      check("t5_ack_rst", ack_user2interface, 0);
      reset = 1'b1;
      op_in_ack = 2'b11;
      stale = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         stale += int'(op_in_vld[0]);
      end
      check("t5_no_stale", stale, 0);

      // Seven words through input lane 0 for the transfer counter
      for (int k = 0; k < 7; k++) begin
         dout_leaf_interface2user[31:0] = 32'h70 + 32'(k);
         vld_interface2user[0] = 1'b1;
         tick();
      end
      vld_interface2user[0] = 1'b0;
      tick();
      tick();
`ifdef LEAF_ADAPTER_XFER_COUNT_EN
      exp_cnt = 32'd7;
`else
      exp_cnt = 32'd0;
`endif
      check("t6_cnt_lane0", xfer_count[31:0], exp_cnt);
      check("t6_cnt_others", (xfer_count[127:32] == '0), 1);

      // Final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
